// File: rtl/sic_exec_mem_lsq_if.sv
// sic_exec_mem_lsq_if: issue, ECR, memory-bus and result signals of the LSQ.
// slave = queue side, master = issue/memory/ECR environment side.
interface sic_exec_mem_lsq_if #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4,
  parameter int NUM_ECRS = 4
);
  localparam int ECR_W = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [ID_WIDTH-1:0]   pkt_id;
  logic [2:0]            pkt_op;
  logic [ECR_W-1:0]      pkt_ecr;
  logic [31:0]           pkt_base;
  logic [15:0]           pkt_imm;
  logic [31:0]           pkt_wdata;
  logic [2*NUM_ECRS-1:0] ecr_state;
  logic                  mem_req;
  logic                  mem_grant;
  logic [29:0]           mem_addr;
  logic [3:0]            mem_be;
  logic                  mem_wen;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  wb_valid;
  logic [ID_WIDTH-1:0]   wb_id;
  logic [31:0]           wb_data;
  logic                  exc_valid;
  logic [ID_WIDTH-1:0]   exc_id;
  logic [CW-1:0]         count;

  modport slave (
    input  pkt_valid, pkt_id, pkt_op, pkt_ecr,
    input  pkt_base, pkt_imm, pkt_wdata,
    input  ecr_state, mem_grant, mem_rdata,
    output pkt_ready, mem_req, mem_addr, mem_be,
    output mem_wen, mem_wdata,
    output wb_valid, wb_id, wb_data,
    output exc_valid, exc_id, count
  );

  modport master (
    output pkt_valid, pkt_id, pkt_op, pkt_ecr,
    output pkt_base, pkt_imm, pkt_wdata,
    output ecr_state, mem_grant, mem_rdata,
    input  pkt_ready, mem_req, mem_addr, mem_be,
    input  mem_wen, mem_wdata,
    input  wb_valid, wb_id, wb_data,
    input  exc_valid, exc_id, count
  );
endinterface

// File: rtl/sic_exec_mem_lsq.sv
// sic_exec_mem_lsq: in-order load/store queue gated by ECR speculation state.
// Ports: clk, rst (sync, active high), bus (slave: issue/ECR/memory/result).
module sic_exec_mem_lsq #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4,
  parameter int NUM_ECRS = 4
) (
  input logic               clk,
  input logic               rst,
  sic_exec_mem_lsq_if.slave bus
);
  localparam int ECR_W = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]    live_q;
  logic [ID_WIDTH-1:0] id_q   [DEPTH];
  logic [2:0]          op_q   [DEPTH];
  logic [ECR_W-1:0]    ecr_q  [DEPTH];
  logic [31:0]         addr_q [DEPTH];
  logic [31:0]         wdat_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [ID_WIDTH-1:0] h_id;
  logic [2:0]          h_op;
  logic [ECR_W-1:0]    h_ecr;
  logic [31:0]         h_addr;
  logic [31:0]         h_wd;
  logic [1:0]          h_st;
  logic                h_live;
  logic                is_b, is_h, is_w, is_st;
  logic                misal;
  logic                enq, pop, req, wb, exc, wen;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [31:0]         ld_data;

  assign h_id   = id_q[head_q];
  assign h_op   = op_q[head_q];
  assign h_ecr  = ecr_q[head_q];
  assign h_addr = addr_q[head_q];
  assign h_wd   = wdat_q[head_q];
  assign h_st   = bus.ecr_state[{h_ecr, 1'b0} +: 2];
  // A head whose ECR reads mispredict is treated as dead this cycle.
  assign h_live = live_q[head_q] && (h_st != 2'b10);

  always_comb begin
    is_b  = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    is_st = 1'b0;
    unique case (h_op)
      3'd0, 3'd4: is_b = 1'b1;
      3'd1, 3'd5: is_h = 1'b1;
      3'd2:       is_w = 1'b1;
      3'd3:       begin is_w = 1'b1; is_st = 1'b1; end
      3'd6:       begin is_b = 1'b1; is_st = 1'b1; end
      3'd7:       begin is_h = 1'b1; is_st = 1'b1; end
    endcase
  end

  assign misal = (is_h && h_addr[0]) ||
                 (is_w && (h_addr[1:0] != 2'b00));

  assign bus.pkt_ready = rst || (count_q < CW'(DEPTH));
  assign enq = bus.pkt_valid && bus.pkt_ready && !rst;

  always_comb begin
    req = 1'b0;
    pop = 1'b0;
    wb  = 1'b0;
    exc = 1'b0;
    wen = 1'b0;
    if (!rst && (count_q != '0)) begin
      if (!h_live) begin
        pop = 1'b1;
      end else if (misal) begin
        if (h_st == 2'b01) begin
          exc = 1'b1;
          pop = 1'b1;
        end
      end else begin
        // Loads may run speculatively; stores wait for resolution.
        req = is_st ? (h_st == 2'b01) : 1'b1;
        if (req && bus.mem_grant) begin
          pop = 1'b1;
          wen = is_st;
          wb  = !is_st;
        end
      end
    end
  end

  assign byte_v = bus.mem_rdata[{h_addr[1:0], 3'b000} +: 8];
  assign half_v = h_addr[1] ? bus.mem_rdata[31:16]
                            : bus.mem_rdata[15:0];

  always_comb begin
    ld_data = bus.mem_rdata;
    if (is_b)
      ld_data = h_op[2] ? {24'd0, byte_v}
                        : {{24{byte_v[7]}}, byte_v};
    else if (is_h)
      ld_data = h_op[2] ? {16'd0, half_v}
                        : {{16{half_v[15]}}, half_v};
  end

  assign bus.mem_req   = req;
  assign bus.mem_wen   = wen;
  assign bus.mem_addr  = h_addr[31:2];
  assign bus.mem_be    = is_w ? 4'b1111 :
                         is_h ? (4'b0011 << h_addr[1:0]) :
                                (4'b0001 << h_addr[1:0]);
  assign bus.mem_wdata = is_b ? {4{h_wd[7:0]}} :
                         is_h ? {2{h_wd[15:0]}} : h_wd;
  assign bus.wb_valid  = wb;
  assign bus.wb_id     = wb ? h_id : '0;
  assign bus.wb_data   = wb ? ld_data : '0;
  assign bus.exc_valid = exc;
  assign bus.exc_id    = exc ? h_id : '0;
  assign bus.count     = count_q;

  assign head_d  = pop ? head_q + 1'b1 : head_q;
  assign tail_d  = enq ? tail_q + 1'b1 : tail_q;
  assign count_d = count_q + CW'(enq) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (bus.ecr_state[{ecr_q[i], 1'b0} +: 2] == 2'b10)
          live_q[i] <= 1'b0;
      if (pop)
        live_q[head_q] <= 1'b0;
      if (enq) begin
        live_q[tail_q] <= 1'b1;
        id_q[tail_q]   <= bus.pkt_id;
        op_q[tail_q]   <= bus.pkt_op;
        ecr_q[tail_q]  <= bus.pkt_ecr;
        addr_q[tail_q] <= bus.pkt_base +
                          {{16{bus.pkt_imm[15]}}, bus.pkt_imm};
        wdat_q[tail_q] <= bus.pkt_wdata;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_sic_exec_mem_lsq.sv
// tb_sic_exec_mem_lsq: directed stimulus with writeback/exception scoreboards.
// Drives at posedge+1, checks comb outputs at +2, monitor samples at negedge.
module tb_sic_exec_mem_lsq;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [35:0] exp_wb [$];
  logic [3:0]  exp_exc [$];

  sic_exec_mem_lsq_if #(.DEPTH(4), .ID_WIDTH(4), .NUM_ECRS(4)) bus ();

  sic_exec_mem_lsq #(.DEPTH(4), .ID_WIDTH(4), .NUM_ECRS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] id, input logic [2:0] op,
                     input logic [1:0] ecr, input logic [31:0] base,
                     input logic [15:0] imm, input logic [31:0] wd);
    bus.pkt_valid = 1'b1;
    bus.pkt_id    = id;
    bus.pkt_op    = op;
    bus.pkt_ecr   = ecr;
    bus.pkt_base  = base;
    bus.pkt_imm   = imm;
    bus.pkt_wdata = wd;
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    if (bus.wb_valid) begin
      if (exp_wb.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_wb.pop_front();
        chk("wb_id", {28'd0, bus.wb_id}, {28'd0, e[35:32]});
        chk("wb_data", bus.wb_data, e[31:0]);
      end
    end else begin
      chk("wb_idle_data", bus.wb_data, 32'd0);
    end
    if (bus.exc_valid) begin
      if (exp_exc.size() == 0)
        chk("exc_unexpected", 32'd1, 32'd0);
      else
        chk("exc_id", {28'd0, bus.exc_id},
            {28'd0, exp_exc.pop_front()});
    end else begin
      chk("exc_idle_id", {28'd0, bus.exc_id}, 32'd0);
    end
  end

  initial begin
    rst           = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.pkt_id    = '0;
    bus.pkt_op    = '0;
    bus.pkt_ecr   = '0;
    bus.pkt_base  = '0;
    bus.pkt_imm   = '0;
    bus.pkt_wdata = '0;
    bus.ecr_state = '0;
    bus.mem_grant = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.pkt_ready}, 32'd1);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bus.pkt_ready}, 32'd1);
    chk("post_rst_wbv", {31'd0, bus.wb_valid}, 32'd0);

    // LW id3 0x100+4, grant one cycle late
    enq(4'd3, 3'd2, 2'd0, 32'h100, 16'h0004, 32'd0);
    #1;
    chk("lw_req", {31'd0, bus.mem_req}, 32'd1);
    chk("lw_addr", {2'd0, bus.mem_addr}, 32'h41);
    chk("lw_be", {28'd0, bus.mem_be}, 32'hF);
    tick();
    chk("lw_req_hold", {31'd0, bus.mem_req}, 32'd1);
    chk("lw_addr_hold", {2'd0, bus.mem_addr}, 32'h41);
    exp_wb.push_back({4'd3, 32'hDEADBEEF});
    bus.mem_grant = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_wen", {31'd0, bus.mem_wen}, 32'd0);
    tick();
    bus.mem_grant = 1'b0;
    #1;
    chk("lw_count", {29'd0, bus.count}, 32'd0);
    chk("lw_req_off", {31'd0, bus.mem_req}, 32'd0);

    // Sub-word loads with rdata 0x80112233
    bus.mem_rdata = 32'h80112233;
    enq(4'd5, 3'd0, 2'd0, 32'h103, 16'h0000, 32'd0);
    #1;
    chk("lb_be", {28'd0, bus.mem_be}, 32'h8);
    chk("lb_addr", {2'd0, bus.mem_addr}, 32'h40);
    exp_wb.push_back({4'd5, 32'hFFFFFF80});
    bus.mem_grant = 1'b1;
    tick();
    bus.mem_grant = 1'b0;
    enq(4'd6, 3'd4, 2'd0, 32'h103, 16'h0000, 32'd0);
    exp_wb.push_back({4'd6, 32'h00000080});
    bus.mem_grant = 1'b1;
    tick();
    bus.mem_grant = 1'b0;
    enq(4'd1, 3'd1, 2'd0, 32'h104, 16'hFFFE, 32'd0);
    #1;
    chk("lh_be", {28'd0, bus.mem_be}, 32'hC);
    exp_wb.push_back({4'd1, 32'hFFFF8011});
    bus.mem_grant = 1'b1;
    tick();
    bus.mem_grant = 1'b0;
    enq(4'd2, 3'd5, 2'd0, 32'h102, 16'h0000, 32'd0);
    exp_wb.push_back({4'd2, 32'h00008011});
    bus.mem_grant = 1'b1;
    tick();
    bus.mem_grant = 1'b0;

    // SH waits for ECR1=01; stray grants are ignored
    enq(4'd7, 3'd7, 2'd1, 32'h102, 16'h0000, 32'h0000ABCD);
    bus.mem_grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sh_wait_req", {31'd0, bus.mem_req}, 32'd0);
      chk("sh_wait_wen", {31'd0, bus.mem_wen}, 32'd0);
      chk("sh_wait_cnt", {29'd0, bus.count}, 32'd1);
      tick();
    end
    bus.mem_grant = 1'b0;
    bus.ecr_state[3:2] = 2'b01;
    #1;
    chk("sh_req", {31'd0, bus.mem_req}, 32'd1);
    chk("sh_be", {28'd0, bus.mem_be}, 32'hC);
    chk("sh_wdata", bus.mem_wdata, 32'hABCDABCD);
    chk("sh_wen_nogrant", {31'd0, bus.mem_wen}, 32'd0);
    bus.mem_grant = 1'b1;
    #1;
    chk("sh_wen", {31'd0, bus.mem_wen}, 32'd1);
    tick();
    bus.mem_grant = 1'b0;
    #1;
    chk("sh_count", {29'd0, bus.count}, 32'd0);

    // Fill, then kill all four via ECR2=10
    for (int i = 0; i < 4; i++)
      enq(4'(8 + i), 3'd2, 2'd2, 32'h300, 16'(4 * i), 32'd0);
    #1;
    chk("full_count", {29'd0, bus.count}, 32'd4);
    chk("full_ready", {31'd0, bus.pkt_ready}, 32'd0);
    chk("full_req", {31'd0, bus.mem_req}, 32'd1);
    enq(4'd15, 3'd2, 2'd2, 32'h300, 16'h0000, 32'd0);
    chk("full_noenq", {29'd0, bus.count}, 32'd4);
    bus.ecr_state[5:4] = 2'b10;
    #1;
    chk("kill_req", {31'd0, bus.mem_req}, 32'd0);
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk("kill_count", {29'd0, bus.count}, 32'(i));
    end
    bus.ecr_state[5:4] = 2'b00;

    // Misaligned LW: waits on 00, traps on 01; SW follows
    enq(4'd12, 3'd2, 2'd3, 32'h101, 16'h0000, 32'd0);
    #1;
    chk("mis_wait_exc", {31'd0, bus.exc_valid}, 32'd0);
    chk("mis_wait_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    bus.ecr_state[7:6] = 2'b01;
    exp_exc.push_back(4'd12);
    #1;
    chk("mis_exc", {31'd0, bus.exc_valid}, 32'd1);
    chk("mis_req", {31'd0, bus.mem_req}, 32'd0);
    enq(4'd13, 3'd3, 2'd3, 32'h200, 16'h0000, 32'h12345678);
    #1;
    chk("sw_count", {29'd0, bus.count}, 32'd1);
    chk("sw_req", {31'd0, bus.mem_req}, 32'd1);
    chk("sw_addr", {2'd0, bus.mem_addr}, 32'h80);
    chk("sw_be", {28'd0, bus.mem_be}, 32'hF);
    chk("sw_wdata", bus.mem_wdata, 32'h12345678);
    bus.mem_grant = 1'b1;
    #1;
    chk("sw_wen", {31'd0, bus.mem_wen}, 32'd1);
    tick();
    bus.mem_grant = 1'b0;
    #1;
    chk("sw_count_done", {29'd0, bus.count}, 32'd0);

    // Reset with a load awaiting grant
    enq(4'd14, 3'd2, 2'd0, 32'h100, 16'h0000, 32'd0);
    #1;
    chk("rl_req", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rl_req_rst", {31'd0, bus.mem_req}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rl_count", {29'd0, bus.count}, 32'd0);
    chk("rl_req_after", {31'd0, bus.mem_req}, 32'd0);
    bus.mem_grant = 1'b1;
    #1;
    chk("rl_late_wb", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    bus.mem_grant = 1'b0;
    tick();
    tick();

    chk("wb_left", 32'(exp_wb.size()), 32'd0);
    chk("exc_left", 32'(exp_exc.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
